// File: rtl/dual_lane_sampler_if.sv
// Output word port of the dual-lane sampler: a valid/ready handshake carrying one
// assembled word toward the receive buffer stage.
interface dual_lane_sampler_if #(
    parameter int WORD_W = 8
);
    logic [WORD_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/dual_lane_sampler.sv
// Samples a 2-bit lane pair each clock while enabled and packs the pairs MSB-first
// into words; a completed word that cannot be handed downstream is dropped and flagged.
module dual_lane_sampler #(
    parameter int WORD_W = 8
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                start_enable,
    input  logic [1:0]          data_if,
    dual_lane_sampler_if.master out_port,
    output logic                busy,
    output logic                overflow
);
    localparam int PAIRS = WORD_W / 2;
    localparam int CNT_W = $clog2(PAIRS);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PAIRS - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              ovf_q, ovf_d;
    logic              busy_q, busy_d;

    logic [WORD_W-1:0] shreg_shifted;
    logic              complete;
    logic              drain;

    // data_if[0] is the more significant bit of each incoming pair.
    assign shreg_shifted = {shreg_q[WORD_W-3:0], data_if[0], data_if[1]};
    assign drain         = valid_q && out_port.out_ready;

    // NOTE: every signal assigned here gets a default first, so no path through
    // the case statement leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shreg_d  = shreg_q;
        data_d   = data_q;
        valid_d  = valid_q;
        ovf_d    = ovf_q;
        complete = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_enable) begin
                    shreg_d = shreg_shifted;
                    cnt_d   = CNT_W'(1);
                    ovf_d   = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (start_enable) begin
                    shreg_d = shreg_shifted;
                    if (cnt_q == LAST_IDX) begin
                        complete = 1'b1;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A word may replace the held one only if that one leaves on this same edge.
        if (complete) begin
            if (!valid_q || out_port.out_ready) begin
                data_d  = shreg_shifted;
                valid_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (drain) begin
            valid_d = 1'b0;
        end

        busy_d = (state_d == RUN);
    end

    // NOTE: state registers use non-blocking assignments so every register samples
    // the pre-edge values computed above, independent of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
        end
    end

    assign out_port.out_data  = data_q;
    assign out_port.out_valid = valid_q;
    assign busy               = busy_q;
    assign overflow           = ovf_q;
endmodule

// File: tb/tb_dual_lane_sampler.sv
// Bench for dual_lane_sampler (WORD_W = 8): directed vector table, hand-written
// reset/restart corner cases, and randomized traffic against a pair-list model.
module tb_dual_lane_sampler;
    localparam int WORD_W = 8;

    logic       clk = 1'b0;
    logic       rstn;
    logic       start_enable;
    logic [1:0] data_if;
    logic       busy;
    logic       overflow;

    dual_lane_sampler_if #(.WORD_W(WORD_W)) bus ();

    dual_lane_sampler #(.WORD_W(WORD_W)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .start_enable (start_enable),
        .data_if      (data_if),
        .out_port     (bus),
        .busy         (busy),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        bit       en;
        bit [1:0] pair;
        bit       rdy;
        bit [7:0] exp_data;
        bit       exp_valid;
        bit       exp_busy;
        bit       exp_ovf;
    } vec_t;

    vec_t tbl[$];

    // Behavioural model: the pairs of the current run are kept as a list and a word
    // is formed arithmetically once four have been collected.
    int       m_pairs[$];
    bit       m_running;
    bit       m_valid;
    bit [7:0] m_data;
    bit       m_ovf;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input bit [7:0] d, input bit v,
                                 input bit b, input bit o);
        check({tag, " out_data"},  32'(bus.out_data),  32'(d));
        check({tag, " out_valid"}, 32'(bus.out_valid), 32'(v));
        check({tag, " busy"},      32'(busy),          32'(b));
        check({tag, " overflow"},  32'(overflow),      32'(o));
    endtask

    task automatic model_reset();
        m_pairs.delete();
        m_running = 0;
        m_valid   = 0;
        m_data    = '0;
        m_ovf     = 0;
    endtask

    task automatic model_step(input bit en, input bit [1:0] p, input bit rdy);
        bit complete = 0;
        int word = 0;
        if (en) begin
            if (!m_running) begin
                m_pairs.delete();
                m_ovf = 0;
            end
            m_running = 1;
            m_pairs.push_back(int'(p));
            if (m_pairs.size() == WORD_W / 2) begin
                complete = 1;
                foreach (m_pairs[i]) word = word * 4 + m_pairs[i];
                m_pairs.delete();
            end
        end else begin
            m_running = 0;
            m_pairs.delete();
        end
        if (complete) begin
            if (!m_valid || rdy) begin
                m_data  = word[7:0];
                m_valid = 1;
            end else begin
                m_ovf = 1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 0;
        end
    endtask

    // Drive one cycle of inputs (pair given as its value), clock, then settle.
    task automatic drive(input bit en, input bit [1:0] p, input bit rdy);
        start_enable  = en;
        data_if       = {p[0], p[1]};
        bus.out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        start_enable  = 1'b0;
        data_if       = 2'b00;
        bus.out_ready = 1'b0;
        rstn          = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic add(input bit en, input bit [1:0] p, input bit rdy,
                       input bit [7:0] d, input bit v, input bit b, input bit o);
        vec_t e;
        e.en = en; e.pair = p; e.rdy = rdy;
        e.exp_data = d; e.exp_valid = v; e.exp_busy = b; e.exp_ovf = o;
        tbl.push_back(e);
    endtask

    initial begin
        // First word B1 with latency check, then FF and 00 back to back.
        add(1, 2'd2, 1, 8'h00, 0, 1, 0);
        add(1, 2'd3, 1, 8'h00, 0, 1, 0);
        add(1, 2'd0, 1, 8'h00, 0, 1, 0);
        add(1, 2'd1, 1, 8'hB1, 1, 1, 0);
        add(1, 2'd3, 1, 8'hB1, 0, 1, 0);
        add(1, 2'd3, 1, 8'hB1, 0, 1, 0);
        add(1, 2'd3, 1, 8'hB1, 0, 1, 0);
        add(1, 2'd3, 1, 8'hFF, 1, 1, 0);
        add(1, 2'd0, 1, 8'hFF, 0, 1, 0);
        add(1, 2'd0, 1, 8'hFF, 0, 1, 0);
        add(1, 2'd0, 1, 8'hFF, 0, 1, 0);
        add(1, 2'd0, 1, 8'h00, 1, 1, 0);
        // B1 held with ready low; 4E completes and is dropped.
        add(1, 2'd2, 1, 8'h00, 0, 1, 0);
        add(1, 2'd3, 0, 8'h00, 0, 1, 0);
        add(1, 2'd0, 0, 8'h00, 0, 1, 0);
        add(1, 2'd1, 0, 8'hB1, 1, 1, 0);
        add(1, 2'd1, 0, 8'hB1, 1, 1, 0);
        add(1, 2'd0, 0, 8'hB1, 1, 1, 0);
        add(1, 2'd3, 0, 8'hB1, 1, 1, 0);
        add(1, 2'd2, 0, 8'hB1, 1, 1, 1);
        add(0, 2'd0, 1, 8'hB1, 0, 0, 1);
        // Partial capture abandoned, restart clears overflow, then 55.
        add(1, 2'd3, 1, 8'hB1, 0, 1, 0);
        add(1, 2'd2, 1, 8'hB1, 0, 1, 0);
        add(0, 2'd0, 1, 8'hB1, 0, 0, 0);
        add(1, 2'd1, 1, 8'hB1, 0, 1, 0);
        add(1, 2'd1, 1, 8'hB1, 0, 1, 0);
        add(1, 2'd1, 1, 8'hB1, 0, 1, 0);
        add(1, 2'd1, 1, 8'h55, 1, 1, 0);
        // 55 held; ready pulses exactly on the CC completion edge.
        add(1, 2'd3, 0, 8'h55, 1, 1, 0);
        add(1, 2'd0, 0, 8'h55, 1, 1, 0);
        add(1, 2'd3, 0, 8'h55, 1, 1, 0);
        add(1, 2'd0, 1, 8'hCC, 1, 1, 0);
        add(0, 2'd0, 1, 8'hCC, 0, 0, 0);
        // Disable on what would be the completion edge: no word.
        add(1, 2'd1, 1, 8'hCC, 0, 1, 0);
        add(1, 2'd1, 1, 8'hCC, 0, 1, 0);
        add(1, 2'd1, 1, 8'hCC, 0, 1, 0);
        add(0, 2'd1, 1, 8'hCC, 0, 0, 0);

        do_reset();
        check_outputs("reset", 8'h00, 0, 0, 0);
        drive(0, 2'd0, 0);
        check_outputs("idle", 8'h00, 0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].en, tbl[i].pair, tbl[i].rdy);
            check_outputs($sformatf("vec%0d", i), tbl[i].exp_data, tbl[i].exp_valid,
                          tbl[i].exp_busy, tbl[i].exp_ovf);
        end

        // Asynchronous reset mid-word while a word is held.
        do_reset();
        drive(1, 2'd2, 0);
        drive(1, 2'd3, 0);
        drive(1, 2'd0, 0);
        drive(1, 2'd1, 0);
        check_outputs("pre_rst word", 8'hB1, 1, 1, 0);
        drive(1, 2'd3, 0);
        drive(1, 2'd3, 0);
        drive(1, 2'd3, 0);
        #2;
        rstn = 1'b0;
        #1;
        check_outputs("async_rst", 8'h00, 0, 0, 0);
        @(posedge clk);
        #1;
        check_outputs("in_rst", 8'h00, 0, 0, 0);
        rstn = 1'b1;
        drive(1, 2'd0, 1);
        drive(1, 2'd1, 1);
        drive(1, 2'd2, 1);
        check_outputs("post_rst partial", 8'h00, 0, 1, 0);
        drive(1, 2'd3, 1);
        check_outputs("post_rst word", 8'h1B, 1, 1, 0);

        // Randomized traffic against the model.
        do_reset();
        model_reset();
        for (int c = 0; c < 600; c++) begin
            bit       en  = ($urandom_range(0, 9) != 0);
            bit [1:0] p   = 2'($urandom_range(0, 3));
            bit       rdy = ($urandom_range(0, 2) != 0);
            drive(en, p, rdy);
            model_step(en, p, rdy);
            check_outputs($sformatf("rand%0d", c), m_data, m_valid, m_running, m_ovf);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
